// File: rtl/register_file_pc.sv
// register_file_pc: NREGS x DATA_W register file with three combinational read ports,
// two write ports and a built-in program counter. Optional macro: REGFILE_BYPASS_EN.
module register_file_pc #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       NREGS       = 16,
    parameter int unsigned       ADDR_W      = 4,
    parameter int unsigned       PC_IDX      = 15,
    parameter int unsigned       PC_INC      = 4,
    parameter int unsigned       PC_READ_OFS = 8,
    parameter logic [DATA_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pw,
    input  logic [ADDR_W-1:0] rw,
    input  logic              e,
    input  logic [DATA_W-1:0] pw2,
    input  logic [ADDR_W-1:0] rw2,
    input  logic              e2,
    input  logic              pc_en,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] rc,
    output logic [DATA_W-1:0] pa,
    output logic [DATA_W-1:0] pb,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pcv
);

    localparam logic [ADDR_W-1:0] PC_SEL = ADDR_W'(PC_IDX);
    localparam logic [DATA_W-1:0] INC_V  = DATA_W'(PC_INC);
    localparam logic [DATA_W-1:0] OFS_V  = DATA_W'(PC_READ_OFS);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the whole array is reset so the PC starts at RESET_PC and operands are
            // deterministic; this keeps it in flops, which is intended for a small file.
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= (i == PC_IDX) ? RESET_PC : '0;
        end else begin
            // Port 0 beats port 1, and any explicit write beats the PC increment.
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (e && rw == ADDR_W'(i))
                    regs[i] <= pw;
                else if (e2 && rw2 == ADDR_W'(i))
                    regs[i] <= pw2;
                else if (i == PC_IDX && pc_en)
                    regs[i] <= regs[i] + INC_V;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] sel);
        logic [DATA_W-1:0] v;
        // NOTE: v gets a value on every path before use, so no latch is inferred.
        v = regs[sel];
`ifdef REGFILE_BYPASS_EN
        if (e2 && rw2 == sel)
            v = pw2;
        if (e && rw == sel)
            v = pw;
`endif
        if (sel == PC_SEL)
            v = v + OFS_V;
        return v;
    endfunction

    always_comb begin
        pa  = read_port(ra);
        pb  = read_port(rb);
        pc  = read_port(rc);
        pcv = regs[PC_IDX];
    end

endmodule
